// File: rtl/dp_ram_fifo_ctrl_if.sv
// Client push/pop and RAM-port bundle for dp_ram_fifo_ctrl.
// Slave side is the controller; master side is the client/RAM environment.
interface dp_ram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic                  i_push;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic                  i_pop;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_rvalid;
    logic                  o_full;
    logic                  o_empty;
    logic [ADDR_WIDTH:0]   o_count;
    logic                  o_afull;
    logic                  o_aempty;
    logic                  o_ovf;
    logic                  o_udf;
    logic [ADDR_WIDTH-1:0] o_ram_waddr;
    logic                  o_ram_wen;
    logic [DATA_WIDTH-1:0] o_ram_wdata;
    logic [ADDR_WIDTH-1:0] o_ram_raddr;
    logic                  o_ram_ren;
    logic [DATA_WIDTH-1:0] i_ram_rdata;

    modport slave (
        input  i_push, i_wdata, i_pop, i_ram_rdata,
        output o_rdata, o_rvalid, o_full, o_empty, o_count, o_afull, o_aempty,
               o_ovf, o_udf, o_ram_waddr, o_ram_wen, o_ram_wdata, o_ram_raddr, o_ram_ren
    );

    modport master (
        output i_push, i_wdata, i_pop, i_ram_rdata,
        input  o_rdata, o_rvalid, o_full, o_empty, o_count, o_afull, o_aempty,
               o_ovf, o_udf, o_ram_waddr, o_ram_wen, o_ram_wdata, o_ram_raddr, o_ram_ren
    );
endinterface

// File: rtl/dp_ram_fifo_ctrl.sv
// Single-clock FIFO controller for a dual-port RAM; almost flags under DP_RAM_FIFO_AFLAGS_EN.
// Latency: pop accepted in cycle N gives o_rvalid/o_rdata in cycle N+1 (RAM read is registered).
// Backpressure: push refused while full (sets o_ovf), pop refused while empty (sets o_udf).
module dp_ram_fifo_ctrl #(
    parameter int RAM_DEPTH     = 1024,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 10,
    parameter int AFULL_THRESH  = RAM_DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    dp_ram_fifo_ctrl_if.slave   bus
);
    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] ptr_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    localparam ptr_t PTR_LAST = ptr_t'(RAM_DEPTH - 1);
    localparam ptr_t PTR_ONE  = ptr_t'(1);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t CNT_FULL = cnt_t'(RAM_DEPTH);

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic full_q, full_d;
    logic empty_q, empty_d;
    logic rvalid_q, rvalid_d;
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;
    logic push_ok, pop_ok;

    // Accept decisions use only registered status, so no push-to-pop bypass exists.
    assign push_ok = bus.i_push & ~full_q;
    assign pop_ok  = bus.i_pop  & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d   = (count_d == CNT_FULL);
        empty_d  = (count_d == '0);
        rvalid_d = pop_ok;
        ovf_d    = ovf_q | (bus.i_push & full_q);
        udf_d    = udf_q | (bus.i_pop & empty_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    localparam cnt_t AFULL_C  = cnt_t'(AFULL_THRESH);
    localparam cnt_t AEMPTY_C = cnt_t'(AEMPTY_THRESH);

`ifdef DP_RAM_FIFO_AFLAGS_EN
    logic afull_q, afull_d;
    logic aempty_q, aempty_d;

    always_comb begin
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    assign bus.o_afull  = afull_q;
    assign bus.o_aempty = aempty_q;
`else
    // Thresholds only matter when the almost flags are built.
    logic unused_thresh;
    assign unused_thresh = ^{AFULL_C, AEMPTY_C};
    assign bus.o_afull   = 1'b0;
    assign bus.o_aempty  = 1'b0;
`endif

    assign bus.o_ram_wen   = push_ok;
    assign bus.o_ram_waddr = wr_ptr_q;
    assign bus.o_ram_wdata = word_t'(bus.i_wdata);
    assign bus.o_ram_ren   = pop_ok;
    assign bus.o_ram_raddr = rd_ptr_q;
    assign bus.o_rdata     = word_t'(bus.i_ram_rdata);
    assign bus.o_rvalid    = rvalid_q;
    assign bus.o_count     = count_q;
    assign bus.o_full      = full_q;
    assign bus.o_empty     = empty_q;
    assign bus.o_ovf       = ovf_q;
    assign bus.o_udf       = udf_q;
endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Directed bench: depth-16 instance (vector table, fill/drain, reset) and depth-5 instance (wrap, ovf).
module tb_dp_ram_fifo_ctrl;
    logic clk = 1'b0;
    logic rst_a_n = 1'b1;
    logic rst_b_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dp_ram_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_a ();
    dp_ram_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus_b ();

    dp_ram_fifo_ctrl #(.RAM_DEPTH(16), .DATA_WIDTH(8), .ADDR_WIDTH(4),
                       .AFULL_THRESH(12), .AEMPTY_THRESH(4))
        dut_a (.i_clk(clk), .i_rst_n(rst_a_n), .bus(bus_a));

    dp_ram_fifo_ctrl #(.RAM_DEPTH(5), .DATA_WIDTH(8), .ADDR_WIDTH(3),
                       .AFULL_THRESH(1), .AEMPTY_THRESH(1))
        dut_b (.i_clk(clk), .i_rst_n(rst_b_n), .bus(bus_b));

    // RAM models with a registered read port.
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [8];
    always @(posedge clk) begin
        if (bus_a.o_ram_wen) mem_a[bus_a.o_ram_waddr] <= bus_a.o_ram_wdata;
        if (bus_a.o_ram_ren) bus_a.i_ram_rdata <= mem_a[bus_a.o_ram_raddr];
        if (bus_b.o_ram_wen) mem_b[bus_b.o_ram_waddr] <= bus_b.o_ram_wdata;
        if (bus_b.o_ram_ren) bus_b.i_ram_rdata <= mem_b[bus_b.o_ram_raddr];
    end

    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] wdata;
        logic       wen;
        logic [3:0] waddr;
        logic       ren;
        logic [3:0] raddr;
        logic       rvalid;
        logic [7:0] rdata;
        logic [4:0] count;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vec [10];
    logic [7:0] q_a [$];
    logic [7:0] q_b [$];
    logic [7:0] exp_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_af_a(input string tag, input int cnt);
`ifdef DP_RAM_FIFO_AFLAGS_EN
        chk({tag, "_afull"},  bus_a.o_afull,  (cnt >= 12) ? 1 : 0);
        chk({tag, "_aempty"}, bus_a.o_aempty, (cnt <= 4) ? 1 : 0);
`else
        chk({tag, "_afull"},  bus_a.o_afull,  0);
        chk({tag, "_aempty"}, bus_a.o_aempty, 0);
`endif
    endtask

    task automatic drive_a(input logic p, input logic q, input logic [7:0] d);
        @(negedge clk);
        bus_a.i_push  = p;
        bus_a.i_pop   = q;
        bus_a.i_wdata = d;
        #1;
    endtask

    task automatic drive_b(input logic p, input logic q, input logic [7:0] d);
        @(negedge clk);
        bus_b.i_push  = p;
        bus_b.i_pop   = q;
        bus_b.i_wdata = d;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec[0] = '{1, 0, 8'h11, 1, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0};
        vec[1] = '{1, 0, 8'h22, 1, 1, 0, 0, 0, 8'h00, 2, 0, 0, 0, 0};
        vec[2] = '{1, 0, 8'h33, 1, 2, 0, 0, 0, 8'h00, 3, 0, 0, 0, 0};
        vec[3] = '{0, 1, 8'h00, 0, 0, 1, 0, 1, 8'h11, 2, 0, 0, 0, 0};
        vec[4] = '{0, 1, 8'h00, 0, 0, 1, 1, 1, 8'h22, 1, 0, 0, 0, 0};
        vec[5] = '{0, 1, 8'h00, 0, 0, 1, 2, 1, 8'h33, 0, 0, 1, 0, 0};
        vec[6] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0};
        vec[7] = '{1, 1, 8'hA5, 1, 3, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1};
        vec[8] = '{1, 1, 8'h5A, 1, 4, 1, 3, 1, 8'hA5, 1, 0, 0, 0, 1};
        vec[9] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1};

        bus_a.i_push = 1'b0; bus_a.i_pop = 1'b0; bus_a.i_wdata = 8'h00;
        bus_b.i_push = 1'b0; bus_b.i_pop = 1'b0; bus_b.i_wdata = 8'h00;
        #1;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        #1;
        chk("rst_count", bus_a.o_count, 0);
        chk("rst_empty", bus_a.o_empty, 1);
        chk("rst_full", bus_a.o_full, 0);
        chk("rst_rvalid", bus_a.o_rvalid, 0);
        chk("rst_ovf", bus_a.o_ovf, 0);
        chk("rst_udf", bus_a.o_udf, 0);
        chk("rst_wen", bus_a.o_ram_wen, 0);
        chk("rst_ren", bus_a.o_ram_ren, 0);
        chk_af_a("rst", 0);
        chk("rst_b_empty", bus_b.o_empty, 1);
        repeat (2) @(negedge clk);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        // Table-driven basic push/pop and simultaneous push/pop while empty.
        for (int i = 0; i < 10; i++) begin
            drive_a(vec[i].push, vec[i].pop, vec[i].wdata);
            chk($sformatf("v%0d_wen", i), bus_a.o_ram_wen, vec[i].wen);
            if (vec[i].wen) chk($sformatf("v%0d_waddr", i), bus_a.o_ram_waddr, vec[i].waddr);
            chk($sformatf("v%0d_ren", i), bus_a.o_ram_ren, vec[i].ren);
            if (vec[i].ren) chk($sformatf("v%0d_raddr", i), bus_a.o_ram_raddr, vec[i].raddr);
            after_edge();
            chk($sformatf("v%0d_rvalid", i), bus_a.o_rvalid, vec[i].rvalid);
            if (vec[i].rvalid) chk($sformatf("v%0d_rdata", i), bus_a.o_rdata, vec[i].rdata);
            chk($sformatf("v%0d_count", i), bus_a.o_count, vec[i].count);
            chk($sformatf("v%0d_full", i), bus_a.o_full, vec[i].full);
            chk($sformatf("v%0d_empty", i), bus_a.o_empty, vec[i].empty);
            chk($sformatf("v%0d_ovf", i), bus_a.o_ovf, vec[i].ovf);
            chk($sformatf("v%0d_udf", i), bus_a.o_udf, vec[i].udf);
            chk_af_a($sformatf("v%0d", i), int'(vec[i].count));
        end

        // Fill from count 1 to full: write pointer wraps, almost flags cross thresholds.
        q_a.push_back(8'h5A);
        for (int k = 0; k < 15; k++) begin
            drive_a(1'b1, 1'b0, 8'hC0 + 8'(k));
            chk($sformatf("fill%0d_wen", k), bus_a.o_ram_wen, 1);
            chk($sformatf("fill%0d_waddr", k), bus_a.o_ram_waddr, (5 + k) % 16);
            q_a.push_back(8'hC0 + 8'(k));
            after_edge();
            chk($sformatf("fill%0d_count", k), bus_a.o_count, 2 + k);
            chk($sformatf("fill%0d_full", k), bus_a.o_full, (k == 14) ? 1 : 0);
            chk_af_a($sformatf("fill%0d", k), 2 + k);
        end
        drive_a(1'b1, 1'b0, 8'hEE);
        chk("a_ovf_wen", bus_a.o_ram_wen, 0);
        after_edge();
        chk("a_ovf_flag", bus_a.o_ovf, 1);
        chk("a_ovf_count", bus_a.o_count, 16);

        // Drain down to count 2, read pointer wraps.
        for (int k = 0; k < 14; k++) begin
            drive_a(1'b0, 1'b1, 8'h00);
            chk($sformatf("drain%0d_ren", k), bus_a.o_ram_ren, 1);
            chk($sformatf("drain%0d_raddr", k), bus_a.o_ram_raddr, (4 + k) % 16);
            exp_d = q_a.pop_front();
            after_edge();
            chk($sformatf("drain%0d_rvalid", k), bus_a.o_rvalid, 1);
            chk($sformatf("drain%0d_rdata", k), bus_a.o_rdata, exp_d);
            chk($sformatf("drain%0d_count", k), bus_a.o_count, 15 - k);
            chk_af_a($sformatf("drain%0d", k), 15 - k);
        end

        // Pop from count 2, then reset while its read data is being presented.
        drive_a(1'b0, 1'b1, 8'h00);
        after_edge();
        chk("pre_rst_rvalid", bus_a.o_rvalid, 1);
        #1;
        rst_a_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", bus_a.o_rvalid, 0);
        chk("mid_rst_count", bus_a.o_count, 0);
        chk("mid_rst_empty", bus_a.o_empty, 1);
        chk("mid_rst_ovf", bus_a.o_ovf, 0);
        chk("mid_rst_udf", bus_a.o_udf, 0);
        chk("mid_rst_ren", bus_a.o_ram_ren, 0);
        chk_af_a("mid_rst", 0);
        bus_a.i_pop = 1'b0;
        @(negedge clk);
        rst_a_n = 1'b1;
        after_edge();
        chk("post_rst_rvalid", bus_a.o_rvalid, 0);
        chk("post_rst_count", bus_a.o_count, 0);

        // Depth-5 instance: fill, overflow, wrap of both pointers, underflow.
        for (int k = 0; k < 5; k++) begin
            drive_b(1'b1, 1'b0, 8'h40 + 8'(k));
            chk($sformatf("b_fill%0d_waddr", k), bus_b.o_ram_waddr, k);
            q_b.push_back(8'h40 + 8'(k));
            after_edge();
            chk($sformatf("b_fill%0d_count", k), bus_b.o_count, k + 1);
        end
        chk("b_full", bus_b.o_full, 1);
        drive_b(1'b1, 1'b0, 8'h99);
        chk("b_ovf_wen", bus_b.o_ram_wen, 0);
        after_edge();
        chk("b_ovf", bus_b.o_ovf, 1);
        chk("b_ovf_count", bus_b.o_count, 5);
        drive_b(1'b0, 1'b1, 8'h00);
        chk("b_pop_raddr", bus_b.o_ram_raddr, 0);
        exp_d = q_b.pop_front();
        after_edge();
        chk("b_pop_rdata", bus_b.o_rdata, exp_d);
        chk("b_pop_full", bus_b.o_full, 0);
        drive_b(1'b1, 1'b0, 8'h77);
        chk("b_wrap_wen", bus_b.o_ram_wen, 1);
        chk("b_wrap_waddr", bus_b.o_ram_waddr, 0);
        q_b.push_back(8'h77);
        after_edge();
        chk("b_wrap_full", bus_b.o_full, 1);
        for (int k = 0; k < 5; k++) begin
            drive_b(1'b0, 1'b1, 8'h00);
            chk($sformatf("b_drain%0d_raddr", k), bus_b.o_ram_raddr, (k + 1) % 5);
            exp_d = q_b.pop_front();
            after_edge();
            chk($sformatf("b_drain%0d_rdata", k), bus_b.o_rdata, exp_d);
            chk($sformatf("b_drain%0d_count", k), bus_b.o_count, 4 - k);
        end
        chk("b_empty", bus_b.o_empty, 1);
        chk("b_udf_pre", bus_b.o_udf, 0);
        drive_b(1'b0, 1'b1, 8'h00);
        chk("b_udf_ren", bus_b.o_ram_ren, 0);
        after_edge();
        chk("b_udf", bus_b.o_udf, 1);
        chk("b_udf_rvalid", bus_b.o_rvalid, 0);
        chk("b_ovf_sticky", bus_b.o_ovf, 1);
        bus_b.i_pop = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dp_ram_fifo_ctrl.md
Name: dp_ram_fifo_ctrl

Overview:
- Single-clock FIFO controller that drives both ports of the team's dual-port RAM.
- Generates the write-side address/enable/data and the read-side address/enable, and consumes the registered read data.
- Tracks occupancy and presents a push/pop interface with full/empty status to the client logic.
- Sits between a producer/consumer pair and one RAM instance. Both RAM clocks are tied to i_clk.

Parameters:
- RAM_DEPTH, 1024: number of usable entries. Any value from 2 to 2**ADDR_WIDTH; power of two not required.
- DATA_WIDTH, 8: word width.
- ADDR_WIDTH, 10: RAM address width.
- AFULL_THRESH, RAM_DEPTH-4: almost-full asserts when count >= value. Used only with the optional feature.
- AEMPTY_THRESH, 4: almost-empty asserts when count <= value. Used only with the optional feature.

Ports:
- i_clk, input, 1: clock for all logic and both RAM ports.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_push, input, 1: push request.
- i_wdata, input, DATA_WIDTH: push data.
- i_pop, input, 1: pop request.
- o_rdata, output, DATA_WIDTH: popped word. Meaningful only while o_rvalid is 1.
- o_rvalid, output, 1: o_rdata valid. One-cycle pulse per accepted pop.
- o_full, output, 1: count == RAM_DEPTH.
- o_empty, output, 1: count == 0.
- o_count, output, ADDR_WIDTH+1: current occupancy.
- o_afull, output, 1: almost full. Optional feature.
- o_aempty, output, 1: almost empty. Optional feature.
- o_ovf, output, 1: sticky flag, set by a push attempted while full.
- o_udf, output, 1: sticky flag, set by a pop attempted while empty.
- o_ram_waddr, output, ADDR_WIDTH: RAM write address.
- o_ram_wen, output, 1: RAM write enable.
- o_ram_wdata, output, DATA_WIDTH: RAM write data.
- o_ram_raddr, output, ADDR_WIDTH: RAM read address.
- o_ram_ren, output, 1: RAM read enable.
- i_ram_rdata, input, DATA_WIDTH: RAM read data, registered inside the RAM with 1-cycle latency.

Behaviour:
- Reset, asynchronous on i_rst_n low:
  - wr_ptr = rd_ptr = 0, count = 0.
  - o_empty = 1, o_full = 0, o_rvalid = 0, o_ovf = 0, o_udf = 0.
  - o_ram_wen = o_ram_ren = 0.
  - o_afull = 0; o_aempty = 1 when the feature is enabled.
  - A pop in flight at reset is discarded: o_rvalid stays 0 after reset release.
- Push accept:
  - push_ok = i_push & ~o_full, using full from the registered state at the start of the cycle.
  - o_ram_wen = push_ok (combinational), o_ram_waddr = wr_ptr, o_ram_wdata = i_wdata.
- Pop accept:
  - pop_ok = i_pop & ~o_empty.
  - o_ram_ren = pop_ok (combinational), o_ram_raddr = rd_ptr.
- Read latency: o_rvalid = registered pop_ok. o_rdata = i_ram_rdata passed through, valid in the cycle after the accept.
- Pointer wrap: each pointer increments on its accept. A pointer at RAM_DEPTH-1 wraps to 0, which covers non-power-of-two depths.
- Count update:
  - +1 on push_ok only; -1 on pop_ok only.
  - Unchanged when both accept or neither accepts.
  - o_full, o_empty and o_count are registered, derived from next-count.
- Simultaneous push and pop:
  - When full: pop accepted, push rejected, o_ovf set.
  - When empty: push accepted, pop rejected, o_udf set.
  - No same-cycle bypass from push to pop.
  - Otherwise both are accepted and count holds.
- Address collision: read and write addresses are never equal in a cycle where both are enabled. Equality implies empty or full, and either condition blocks one side.
- Error flags: o_ovf and o_udf are sticky and cleared only by reset. A rejected request has no other effect.

Optional Feature:
- Macro: DP_RAM_FIFO_AFLAGS_EN.
- Defined:
  - o_afull = (next_count >= AFULL_THRESH), registered.
  - o_aempty = (next_count <= AEMPTY_THRESH), registered.
  - Both update in the same cycle as o_count.
- Undefined:
  - o_afull is tied 0 and o_aempty is tied 0.
  - No comparator logic is built.
  - The threshold parameters are ignored.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> o_ram_waddr 0, 1, 2 with o_ram_wen=1; o_count=3; o_empty=0.
- Pop 3 times back-to-back -> o_ram_raddr 0, 1, 2; o_rvalid high one cycle after each accept with o_rdata 0x11, 0x22, 0x33; o_empty=1 after the third pop.
- RAM_DEPTH=5, ADDR_WIDTH=3; push 5 -> o_full=1. Push again -> o_ram_wen=0, o_ovf=1. Pop 1, then push 1 -> o_ram_waddr=0, confirming wrap.
- Empty FIFO, i_push=i_pop=1 with i_wdata=0xA5 -> push accepted, pop rejected, o_udf=1, o_count=1. Next cycle both high -> both accepted, count stays 1, o_rdata=0xA5.
- FIFO at count 2; assert i_rst_n=0 mid-cycle while a pop is in flight -> outputs go to reset values immediately; o_rvalid=0 after release.
- With DP_RAM_FIFO_AFLAGS_EN, RAM_DEPTH=16, AFULL_THRESH=12, AEMPTY_THRESH=4 -> o_aempty drops when count reaches 5; o_afull rises when count reaches 12. Without the macro, both stay 0.
